// File: rtl/handshake_pkg.sv
// Shared types, constants and helpers for registered valid/ready handshake units.
package handshake_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Replicated to the payload width wherever a reset payload is needed.
    localparam bit HS_IDLE_DATA = 1'b0;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/handshake_one_slot_buffer.sv
// One-slot registered valid/ready buffer; accepts a new token in the same cycle
// the held one is taken, so it sustains one token per cycle.
module handshake_one_slot_buffer
    import handshake_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    slot_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign in_ready_o  = (state_q == SLOT_EMPTY) || out_ready_i;
    assign out_valid_o = (state_q == SLOT_FULL);
    assign out_data_o  = data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (in_valid_i && in_ready_o) begin
            state_d = SLOT_FULL;
            data_d  = in_data_i;
        end else if ((state_q == SLOT_FULL) && out_ready_i) begin
            // Drained with no refill: payload is kept, only validity drops.
            state_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SLOT_EMPTY;
            data_q  <= {DATA_WIDTH{HS_IDLE_DATA}};
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/handshake_constant_seq.sv
// Registered constant source: each ctrl token emits the next entry of a
// compile-time table, wrapping or saturating at the last entry.
module handshake_constant_seq
    import handshake_pkg::*;
#(
    parameter int unsigned                 DATA_WIDTH = 32,
    parameter int unsigned                 DEPTH      = 4,
    parameter logic [DEPTH*DATA_WIDTH-1:0] VALUES     = '0,
    parameter bit                          WRAP       = 1'b1,
    parameter int unsigned                 IDX_W      = clog2_min1(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_valid,
    output logic                  ctrl_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready,
    output logic [IDX_W-1:0]      seq_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0]      seq_idx_q, seq_idx_d;
    logic [DATA_WIDTH-1:0] table_data;
    logic                  ctrl_fire;

    assign ctrl_fire  = ctrl_valid && ctrl_ready;
    assign table_data = VALUES[seq_idx_q*DATA_WIDTH +: DATA_WIDTH];
    assign seq_idx    = seq_idx_q;

    always_comb begin
        seq_idx_d = seq_idx_q;
        if (ctrl_fire) begin
            if (seq_idx_q == LAST_IDX) begin
                seq_idx_d = WRAP ? '0 : LAST_IDX;
            end else begin
                seq_idx_d = seq_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seq_idx_q <= '0;
        end else begin
            seq_idx_q <= seq_idx_d;
        end
    end

    handshake_one_slot_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (ctrl_valid),
        .in_ready_o  (ctrl_ready),
        .in_data_i   (table_data),
        .out_valid_o (outs_valid),
        .out_ready_i (outs_ready),
        .out_data_o  (outs)
    );

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Directed-vector and randomized-handshake bench for handshake_constant_seq.
module tb_handshake_constant_seq;

    logic clk = 1'b0;
    logic rst, ctrl_valid, outs_ready;

    logic       a_ready, a_valid, b_ready, b_valid, c_ready, c_valid;
    logic [7:0] a_outs, b_outs, c_outs;
    logic [1:0] a_idx, b_idx;
    logic [0:0] c_idx;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    handshake_constant_seq #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .VALUES     (32'h44332211),
        .WRAP       (1'b1)
    ) dut_wrap (
        .clk (clk), .rst (rst), .ctrl_valid (ctrl_valid), .ctrl_ready (a_ready),
        .outs (a_outs), .outs_valid (a_valid), .outs_ready (outs_ready), .seq_idx (a_idx)
    );

    handshake_constant_seq #(
        .DATA_WIDTH (8),
        .DEPTH      (4),
        .VALUES     (32'h44332211),
        .WRAP       (1'b0)
    ) dut_sat (
        .clk (clk), .rst (rst), .ctrl_valid (ctrl_valid), .ctrl_ready (b_ready),
        .outs (b_outs), .outs_valid (b_valid), .outs_ready (outs_ready), .seq_idx (b_idx)
    );

    handshake_constant_seq #(
        .DATA_WIDTH (8),
        .DEPTH      (1),
        .VALUES     (8'h5A),
        .WRAP       (1'b1)
    ) dut_one (
        .clk (clk), .rst (rst), .ctrl_valid (ctrl_valid), .ctrl_ready (c_ready),
        .outs (c_outs), .outs_valid (c_valid), .outs_ready (outs_ready), .seq_idx (c_idx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ctrl_ready expectation is taken before the edge; the rest after it.
    typedef struct {
        logic       rst, cv, ordy, chk_rdy, rdy, ov;
        logic [7:0] outs;
        logic [1:0] idx;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    logic [7:0] golden[4];
    logic [7:0] sat_exp[6];
    logic [1:0] sat_idx[6];

    int unsigned fire_cnt, deliver_cnt;
    logic        model_valid, exp_rdy;

    initial begin
        golden  = '{8'h11, 8'h22, 8'h33, 8'h44};
        sat_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44, 8'h44};
        sat_idx = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        vecs = '{
            // reset held with ctrl_valid=1: nothing emitted
            '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0},
            // streaming with wrap
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 2'd3},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h44, 2'd0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2},
            // drain only: valid drops, payload holds
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 2'd2},
            // backpressure
            '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 2'd1},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 2'd2},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h22, 2'd2},
            // mid-operation reset while stalled on 33
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd3},
            '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h33, 2'd3},
            '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0},
            '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 2'd1},
            '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 2'd1}
        };

        rst = 1'b1; ctrl_valid = 1'b0; outs_ready = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; ctrl_valid = vecs[i].cv; outs_ready = vecs[i].ordy;
            #1;
            if (vecs[i].chk_rdy) check($sformatf("vec%0d ctrl_ready", i), 32'(a_ready), 32'(vecs[i].rdy));
            @(posedge clk); #1;
            check($sformatf("vec%0d outs_valid", i), 32'(a_valid), 32'(vecs[i].ov));
            check($sformatf("vec%0d outs", i), 32'(a_outs), 32'(vecs[i].outs));
            check($sformatf("vec%0d seq_idx", i), 32'(a_idx), 32'(vecs[i].idx));
        end

        // Saturating and single-entry instances under continuous streaming.
        @(negedge clk);
        rst = 1'b1; ctrl_valid = 1'b1; outs_ready = 1'b1;
        @(posedge clk); #1;
        check("sat reset valid", 32'(b_valid), 32'd0);
        check("sat reset idx", 32'(b_idx), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = 1'b0; ctrl_valid = 1'b1; outs_ready = 1'b1;
            #1;
            check($sformatf("sat%0d ctrl_ready", i), 32'(b_ready), 32'd1);
            check($sformatf("one%0d ctrl_ready", i), 32'(c_ready), 32'd1);
            @(posedge clk); #1;
            check($sformatf("sat%0d outs_valid", i), 32'(b_valid), 32'd1);
            check($sformatf("sat%0d outs", i), 32'(b_outs), 32'(sat_exp[i]));
            check($sformatf("sat%0d seq_idx", i), 32'(b_idx), 32'(sat_idx[i]));
            check($sformatf("one%0d outs", i), 32'(c_outs), 32'h5A);
            check($sformatf("one%0d seq_idx", i), 32'(c_idx), 32'd0);
        end

        // Random handshakes against a one-slot model of the wrapping instance.
        @(negedge clk);
        rst = 1'b1; ctrl_valid = 1'b0; outs_ready = 1'b0;
        @(posedge clk); #1;
        fire_cnt = 0; deliver_cnt = 0; model_valid = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            ctrl_valid = 1'($urandom_range(0, 1));
            outs_ready = 1'($urandom_range(0, 1));
            #1;
            exp_rdy = !model_valid || outs_ready;
            check("rand ctrl_ready", 32'(a_ready), 32'(exp_rdy));
            check("rand outs_valid", 32'(a_valid), 32'(model_valid));
            if (model_valid && outs_ready) begin
                check("rand outs", 32'(a_outs), 32'(golden[deliver_cnt % 4]));
                deliver_cnt++;
            end
            if (ctrl_valid && exp_rdy) fire_cnt++;
            model_valid = (ctrl_valid && exp_rdy) || (model_valid && !outs_ready);
            @(posedge clk);
        end
        #1;
        check("rand token count", deliver_cnt + 32'(model_valid), fire_cnt);
        check("rand seq_idx", 32'(a_idx), fire_cnt % 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
